halt_ctrl: RTL
==============

# halt_ctrl

Simulation halt and trap-reporting controller for the RV64 core. It sits directly downstream of the environment-call stage and consumes its ebreak indication, together with the retiring PC and the a0 (x10) value. It freezes the core through a drain/halt state machine and reports a good/bad trap verdict. It also maintains cycle and retired-instruction counters, plus a no-retire watchdog that forces a bad trap on a hung core.

## Interface
Parameters:
- CNT_W, 64: width of the cycle and instruction counters.
- WDT_LIMIT, 1024: consecutive RUN cycles without a retire before a forced trap; 0 disables the watchdog.
- DRAIN_CYCLES, 2: cycles spent in DRAIN before HALT; legal range 1..15.

Ports (all outputs registered; the clock is clk, and the reset is rst_n, asynchronous and active-low):
- clk  in  1  core clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_valid  in  1  one instruction retires this cycle.
- ebreak_req  in  1  the retiring instruction is ebreak; valid only when inst_valid=1.
- ebreak_pc  in  64  PC of the ebreak instruction.
- ebreak_a0  in  64  x10 value at the ebreak.
- halt  out  1  freezes PC update and register-file/memory writes.
- trap_valid  out  1  one-cycle pulse on entry to HALT.
- trap_good  out  1  trap verdict; stable from the trap_valid pulse until reset.
- trap_pc  out  64  captured PC; stable from the trap_valid pulse until reset.
- trap_code  out  64  captured a0, or TRAP_CODE_WDT; stable from the trap_valid pulse until reset.
- wdt_expired  out  1  sticky; the trap was caused by the watchdog.
- cycle_cnt  out  CNT_W  elapsed cycles.
- inst_cnt  out  CNT_W  retired instructions.

## Operation
The block is a three-state FSM: RUN, DRAIN, HALT.

RUN:
- inst_cnt increments on every inst_valid, including the ebreak itself.
- The watchdog counter increments on every cycle with inst_valid=0 and clears on inst_valid=1.
- On inst_valid & ebreak_req: capture trap_pc=ebreak_pc and trap_code=ebreak_a0; trap_good becomes (ebreak_a0==0); go to DRAIN.
- On watchdog count reaching WDT_LIMIT (when WDT_LIMIT≠0): capture trap_pc=0 and trap_code=TRAP_CODE_WDT; set trap_good=0 and wdt_expired=1; go to DRAIN.
- If an ebreak retires in the same cycle the watchdog would fire, the ebreak wins, because a retire clears the watchdog.
- ebreak_req with inst_valid=0 is ignored.

DRAIN:
- halt=1.
- The drain counter loads DRAIN_CYCLES on entry and decrements each cycle; when it reaches 0 the FSM goes to HALT.
- inst_valid is ignored, and inst_cnt is frozen.

HALT:
- Sticky until reset; halt=1.
- trap_valid=1 for only the first cycle.
- Both counters are frozen.
- Further ebreak_req or inst_valid inputs have no effect.

Counters:
- cycle_cnt increments in RUN and DRAIN and is frozen in HALT.
- Both counters wrap modulo 2^CNT_W without saturation.
- The watchdog counter is $clog2(WDT_LIMIT+1) bits wide and never wraps.

## Timing
Reset values:
- State: RUN.
- All outputs are 0: halt, trap_valid, trap_good, wdt_expired, trap_pc, trap_code, cycle_cnt, inst_cnt.
- The internal watchdog and drain counters are 0.

Reset behaviour:
- Reset asserted in any state, including mid-DRAIN, returns everything to these values immediately, asynchronously.
- Release takes effect at the first rising edge with rst_n=1.

Latency (for an ebreak sampled at edge N):
- halt=1 from edge N.
- HALT is entered and trap_valid pulses at edge N+DRAIN_CYCLES.
- trap_valid falls at edge N+DRAIN_CYCLES+1.

Watchdog:
- It fires on the edge at which the count equals WDT_LIMIT, i.e. after WDT_LIMIT idle edges.
- From then on, timing is identical to the ebreak path.

Counter visibility:
- The counters reflect events sampled at the previous edge.
- cycle_cnt=k after k edges in RUN.

## Structure
Shared package riscv_sim_pkg holds:
- the halt_state_e enum (RUN, DRAIN, HALT);
- TRAP_CODE_WDT = 64'hDEAD_0000_0000_0001;
- the localparam defaults for WDT_LIMIT and DRAIN_CYCLES.

One sub-module is natural: wdt_counter. It is parameterized by LIMIT and has inputs clk, rst_n, en, clr and output expired. halt_ctrl holds the FSM, the capture registers and the counters.

## Test plan
1. Reset, then 10 idle-free retires, then ebreak with pc=0x8000_0040 and a0=0 (DRAIN_CYCLES=2). Required: halt rises at the ebreak edge; trap_valid pulses exactly 2 edges later; trap_good=1, trap_pc=0x8000_0040, trap_code=0, inst_cnt=11.
2. Ebreak with a0=5. Required: trap_good=0, trap_code=5, wdt_expired=0.
3. WDT_LIMIT=8, no inst_valid after reset. Required: DRAIN entered at edge 8, trap_valid at edge 10, trap_code=TRAP_CODE_WDT, wdt_expired=1, trap_good=0.
4. With WDT_LIMIT=8, 7 idle cycles, then ebreak in the cycle where the watchdog would reach 8. Required: ebreak verdict, wdt_expired=0; a retire on cycle 7 instead restarts the count.
5. rst_n pulsed low mid-DRAIN. Required: halt and all outputs are 0 immediately; after release, a new ebreak traps normally with counters restarted from 0.
6. In HALT, drive inst_valid and ebreak_req for 20 cycles. Required: cycle_cnt, inst_cnt and the trap outputs are unchanged, and trap_valid stays 0.

Source files
------------

// File: rtl/riscv_sim_pkg.sv
// Shared types and constants for the simulation halt/trap controller.
// Holds the halt FSM encoding, the watchdog trap code and parameter defaults.
package riscv_sim_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } halt_state_e;

  localparam logic [63:0] TRAP_CODE_WDT        = 64'hDEAD_0000_0000_0001;
  localparam int          WDT_LIMIT_DEFAULT    = 1024;
  localparam int          DRAIN_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/wdt_counter.sv
// No-retire watchdog: counts enabled cycles and flags the cycle whose edge
// would bring the count to LIMIT. LIMIT=0 disables it entirely.
module wdt_counter
  import riscv_sim_pkg::*;
#(
  parameter int LIMIT = WDT_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int W = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] count_q, count_d;

  // Saturate at LIMIT rather than wrapping so a hung core can never re-arm.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != W'(LIMIT))) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (LIMIT != 0) && en && !clr && (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/halt_ctrl.sv
// Simulation halt and trap-reporting controller: RUN/DRAIN/HALT FSM, trap
// capture registers, cycle/instruction counters and a no-retire watchdog.
module halt_ctrl
  import riscv_sim_pkg::*;
#(
  parameter int CNT_W        = 64,
  parameter int WDT_LIMIT    = WDT_LIMIT_DEFAULT,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT  // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid,
  input  logic             ebreak_req,
  input  logic [63:0]      ebreak_pc,
  input  logic [63:0]      ebreak_a0,
  output logic             halt,
  output logic             trap_valid,
  output logic             trap_good,
  output logic [63:0]      trap_pc,
  output logic [63:0]      trap_code,
  output logic             wdt_expired,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  halt_state_e state_q, state_d;
  logic [3:0]  drainCnt_q, drainCnt_d;

  logic             halt_q, halt_d;
  logic             trapValid_q, trapValid_d;
  logic             trapGood_q, trapGood_d;
  logic [63:0]      trapPc_q, trapPc_d;
  logic [63:0]      trapCode_q, trapCode_d;
  logic             wdtExpired_q, wdtExpired_d;
  logic [CNT_W-1:0] cycleCnt_q, cycleCnt_d;
  logic [CNT_W-1:0] instCnt_q, instCnt_d;

  logic ebreakHit;
  logic wdtFire;
  logic inRun;

  assign inRun     = (state_q == RUN);
  assign ebreakHit = inst_valid && ebreak_req;

  // A retire clears the count, so an ebreak can never lose to the watchdog.
  wdt_counter #(
    .LIMIT(WDT_LIMIT)
  ) u_wdt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (inRun && !inst_valid),
    .clr     (inst_valid || !inRun),
    .expired (wdtFire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      drainCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    unique case (state_q)
      RUN: begin
        if (ebreakHit || wdtFire) begin
          state_d    = DRAIN;
          drainCnt_d = 4'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        drainCnt_d = drainCnt_q - 4'd1;
        if (drainCnt_q == 4'd1) begin
          state_d = HALT;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    halt_d       = (state_d != RUN);
    trapValid_d  = (state_q == DRAIN) && (state_d == HALT);
    trapGood_d   = trapGood_q;
    trapPc_d     = trapPc_q;
    trapCode_d   = trapCode_q;
    wdtExpired_d = wdtExpired_q;
    if (inRun && ebreakHit) begin
      trapGood_d   = (ebreak_a0 == 64'd0);
      trapPc_d     = ebreak_pc;
      trapCode_d   = ebreak_a0;
      wdtExpired_d = 1'b0;
    end else if (inRun && wdtFire) begin
      trapGood_d   = 1'b0;
      trapPc_d     = 64'd0;
      trapCode_d   = TRAP_CODE_WDT;
      wdtExpired_d = 1'b1;
    end
    cycleCnt_d = (state_q != HALT) ? cycleCnt_q + CNT_W'(1) : cycleCnt_q;
    instCnt_d  = (inRun && inst_valid) ? instCnt_q + CNT_W'(1) : instCnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q       <= 1'b0;
      trapValid_q  <= 1'b0;
      trapGood_q   <= 1'b0;
      trapPc_q     <= '0;
      trapCode_q   <= '0;
      wdtExpired_q <= 1'b0;
      cycleCnt_q   <= '0;
      instCnt_q    <= '0;
    end else begin
      halt_q       <= halt_d;
      trapValid_q  <= trapValid_d;
      trapGood_q   <= trapGood_d;
      trapPc_q     <= trapPc_d;
      trapCode_q   <= trapCode_d;
      wdtExpired_q <= wdtExpired_d;
      cycleCnt_q   <= cycleCnt_d;
      instCnt_q    <= instCnt_d;
    end
  end

  assign halt        = halt_q;
  assign trap_valid  = trapValid_q;
  assign trap_good   = trapGood_q;
  assign trap_pc     = trapPc_q;
  assign trap_code   = trapCode_q;
  assign wdt_expired = wdtExpired_q;
  assign cycle_cnt   = cycleCnt_q;
  assign inst_cnt    = instCnt_q;

endmodule
